// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Access sizes, controller states and the read-latency ceiling.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; also flags misaligned half/word accesses.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  off,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] wlane,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] wbase;
  logic [NB-1:0]     be_base;

  always_comb begin
    shifted    = rword >> {off, 3'b000};
    wbase      = '0;
    be_base    = '0;
    rdata      = '0;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wbase[7:0]  = wdata[7:0];
        be_base[0]  = 1'b1;
        rdata       = (shifted[7] & ~is_unsigned) ? '1 : '0;
        rdata[7:0]  = shifted[7:0];
      end
      SZ_H: begin
        wbase[15:0]  = wdata[15:0];
        be_base[1:0] = 2'b11;
        rdata        = (shifted[15] & ~is_unsigned) ? '1 : '0;
        rdata[15:0]  = shifted[15:0];
        misaligned   = off[0];
      end
      SZ_W: begin
        wbase[31:0]  = wdata[31:0];
        be_base[3:0] = 4'hf;
        rdata        = (shifted[31] & ~is_unsigned) ? '1 : '0;
        rdata[31:0]  = shifted[31:0];
        misaligned   = |off[1:0];
      end
      default: ;
    endcase
    wlane = wbase << {off, 3'b000};
    be    = be_base << off;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding load/store, valid/ready
// request, single-cycle response pulse, configurable read latency.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = $clog2(RD_LAT_MAX + 1);
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(NB);

  state_e            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] rword;
  logic [DATA_W-1:0] wlane;
  logic [DATA_W-1:0] ld_data;
  logic [NB-1:0]     be;
  logic              misaligned;
  logic              range_err;
  logic              err;
  logic              accept;

  assign idx       = req_addr[IDX_W+OFF_W-1:OFF_W];
  assign off       = req_addr[OFF_W-1:0];
  assign rword     = mem[idx];
  assign range_err = 64'(req_addr) >= LIMIT;
  assign err       = misaligned | range_err | (req_size == 2'b11);
  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  dmem_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .size       (req_size),
    .off        (off),
    .is_unsigned(req_unsigned),
    .wdata      (req_wdata),
    .rword      (rword),
    .wlane      (wlane),
    .be         (be),
    .rdata      (ld_data),
    .misaligned (misaligned)
  );

  // Array is deliberately not reset; a store accepted before reset stays.
  always_ff @(posedge CLK) begin
    if (accept && req_we && !err && !RESET) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_err   <= err;
            rsp_rdata <= (req_we || err) ? '0 : ld_data;
            if (req_we || err || RD_LAT == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CW'(RD_LAT - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
